// File: rtl/draw_score_if.sv
// vga_if: VGA timing and colour bundle passed between pixel-pipeline stages
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic vsync;
  logic vblnk;
  logic hsync;
  logic hblnk;
  logic [11:0] rgb;
  modport src (input vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport sink (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_score.sv
// draw_score: overlays HITS/MISSES 2-digit BCD scores on the VGA stream, 2-cycle latency
// Ports: clk pixel clock; rst sync active-high reset; hit/miss one-cycle event pulses;
//   clr level, zeroes both counters; vga upstream picture; vga_out overlaid picture.
// Optional: define SCORE_BLINK_EN to blink MISSES for 31 frames after each counted miss.
module draw_score #(
  parameter logic [10:0] HIT_X = 11'd40,
  parameter logic [10:0] MISS_X = 11'd700,
  parameter logic [10:0] SCORE_Y = 11'd20,
  parameter int SCALE_LOG2 = 1,
  parameter logic [11:0] FG_RGB = 12'hFFF
) (
  input logic clk,
  input logic rst,
  input logic hit,
  input logic miss,
  input logic clr,
  vga_if.src vga,
  vga_if.sink vga_out
);
  localparam logic [10:0] CW = 11'(8 << SCALE_LOG2);
  localparam logic [10:0] CH = 11'(16 << SCALE_LOG2);
  logic [7:0] hits, misses, hits_sh, misses_sh;
  logic frame_start, miss_hide;
  assign frame_start = vga.vcount == 11'd0 && vga.hcount == 11'd0;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v == 8'h99 ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  always_ff @(posedge clk)
    if (rst || clr) begin
      hits <= '0;
      misses <= '0;
    end else begin
      if (hit) hits <= bcd_inc(hits);
      if (miss) misses <= bcd_inc(misses);
    end
  // shadows only move at frame start so a frame never shows two values
  always_ff @(posedge clk)
    if (rst) begin
      hits_sh <= '0;
      misses_sh <= '0;
    end else if (frame_start) begin
      hits_sh <= hits;
      misses_sh <= misses;
    end
`ifdef SCORE_BLINK_EN
  logic [4:0] blink;
  always_ff @(posedge clk)
    if (rst || clr) blink <= '0;
    else if (miss && misses != 8'h99) blink <= 5'd31;
    else if (frame_start && blink != 5'd0) blink <= blink - 5'd1;
  assign miss_hide = blink[2];
`else
  assign miss_hide = 1'b0;
`endif
  logic [10:0] hit_dx, miss_dx, dx, dy;
  logic in_y, in_hit, in_miss;
  logic [3:0] digit;
  always_comb begin
    hit_dx = vga.hcount - HIT_X;
    miss_dx = vga.hcount - MISS_X;
    dy = vga.vcount - SCORE_Y;
    in_y = vga.vcount >= SCORE_Y && vga.vcount < SCORE_Y + CH && !vga.vblnk && !vga.hblnk;
    in_hit = in_y && vga.hcount >= HIT_X && vga.hcount < HIT_X + CH;
    in_miss = in_y && !miss_hide && vga.hcount >= MISS_X && vga.hcount < MISS_X + CH;
    dx = in_hit ? hit_dx : miss_dx;
    digit = in_hit ? (dx < CW ? hits_sh[7:4] : hits_sh[3:0])
                   : (dx < CW ? misses_sh[7:4] : misses_sh[3:0]);
  end
  logic act1;
  logic [3:0] digit1, row1;
  logic [2:0] col1;
  logic [10:0] vc1, hc1;
  logic vs1, vb1, hs1, hb1;
  logic [11:0] rgb1;
  always_ff @(posedge clk)
    if (rst) begin
      act1 <= 1'b0;
      digit1 <= '0;
      row1 <= '0;
      col1 <= '0;
      vc1 <= '0;
      hc1 <= '0;
      vs1 <= 1'b0;
      vb1 <= 1'b0;
      hs1 <= 1'b0;
      hb1 <= 1'b0;
      rgb1 <= '0;
    end else begin
      act1 <= in_hit || in_miss;
      digit1 <= digit;
      row1 <= 4'(dy >> SCALE_LOG2);
      col1 <= 3'(dx >> SCALE_LOG2);
      vc1 <= vga.vcount;
      hc1 <= vga.hcount;
      vs1 <= vga.vsync;
      vb1 <= vga.vblnk;
      hs1 <= vga.hsync;
      hb1 <= vga.hblnk;
      rgb1 <= vga.rgb;
    end
  // each glyph is 16 rows packed MSB-first; row 0 sits in bits 127:120
  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [3:0] r);
    logic [127:0] g;
    case (d)
      4'd0: g = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1: g = 128'h00001838781818181818187E00000000;
      4'd2: g = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3: g = 128'h00007CC606063C060606C67C00000000;
      4'd4: g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5: g = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6: g = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7: g = 128'h0000FEC606060C183030303000000000;
      4'd8: g = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9: g = 128'h00007CC6C6C67E0606060C7800000000;
      default: g = '0;
    endcase
    return 8'(g >> {~r, 3'b000});
  endfunction
  logic [7:0] row_bits;
  assign row_bits = font_row(digit1, row1);
  always_ff @(posedge clk)
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.hcount <= '0;
      vga_out.vsync <= 1'b0;
      vga_out.vblnk <= 1'b0;
      vga_out.hsync <= 1'b0;
      vga_out.hblnk <= 1'b0;
      vga_out.rgb <= '0;
    end else begin
      vga_out.vcount <= vc1;
      vga_out.hcount <= hc1;
      vga_out.vsync <= vs1;
      vga_out.vblnk <= vb1;
      vga_out.hsync <= hs1;
      vga_out.hblnk <= hb1;
      vga_out.rgb <= act1 && row_bits[~col1] ? FG_RGB : rgb1;
    end
endmodule

// File: tb/tb_draw_score.sv
// tb_draw_score: randomized self-checking bench for draw_score against an integer score model
module tb_draw_score;
  localparam int S = 1;
  localparam int CW = 8 << S;
  localparam int CH = 16 << S;
  localparam int HX = 40;
  localparam int MX = 100;
  localparam int SY = 20;
  localparam logic [127:0] FONT [10] = '{
    128'h00007CC6C6CEDEF6E6C6C67C00000000, 128'h00001838781818181818187E00000000,
    128'h00007CC6060C183060C0C6FE00000000, 128'h00007CC606063C060606C67C00000000,
    128'h00000C1C3C6CCCFE0C0C0C1E00000000, 128'h0000FEC0C0C0FC060606C67C00000000,
    128'h00003860C0C0FCC6C6C6C67C00000000, 128'h0000FEC606060C183030303000000000,
    128'h00007CC6C6C67CC6C6C6C67C00000000, 128'h00007CC6C6C67E0606060C7800000000};
  logic clk = 1'b0, rst = 1'b1, hit = 1'b0, miss = 1'b0, clr = 1'b0;
  vga_if vin ();
  vga_if vout ();
  draw_score #(.HIT_X(11'd40), .MISS_X(11'd100), .SCORE_Y(11'd20), .SCALE_LOG2(S), .FG_RGB(12'hFFF)) dut (
    .clk(clk), .rst(rst), .hit(hit), .miss(miss), .clr(clr), .vga(vin), .vga_out(vout));
  always #5 clk = ~clk;
  int m_hits, m_miss, s_hits, s_miss, m_blink;
  logic [37:0] q[$];
  int ncmp = 0, nfail = 0;
  bit rand_blank = 1'b1;
  function automatic logic [37:0] obs();
    return {vout.vcount, vout.hcount, vout.vsync, vout.vblnk, vout.hsync, vout.hblnk, vout.rgb};
  endfunction
  function automatic bit glyph_on(int val, int dx, int dy);
    int d, row, col;
    logic [127:0] g;
    d = dx < CW ? val / 10 : val % 10;
    row = dy / (1 << S);
    col = (dx / (1 << S)) % 8;
    g = FONT[d];
    return g[127 - 8 * row - col];
  endfunction
  function automatic logic [11:0] exp_rgb(int h, int v, bit vb, bit hb, logic [11:0] rgb);
    if (vb || hb || v < SY || v >= SY + CH) return rgb;
    if (h >= HX && h < HX + 2 * CW) return glyph_on(s_hits, h - HX, v - SY) ? 12'hFFF : rgb;
    if (h >= MX && h < MX + 2 * CW && !(m_blink != 0 && (m_blink & 4) != 0))
      return glyph_on(s_miss, h - MX, v - SY) ? 12'hFFF : rgb;
    return rgb;
  endfunction
  task automatic model_reset();
    m_hits = 0; m_miss = 0; s_hits = 0; s_miss = 0; m_blink = 0;
    q.delete();
    q.push_back('0);
  endtask
  task automatic cyc(input int h, input int v, input bit hi, input bit mi, input bit cl);
    logic [11:0] rgb;
    bit vs, hs, vb, hb, fs;
    rgb = 12'($urandom);
    vs = 1'($urandom_range(0, 1));
    hs = 1'($urandom_range(0, 1));
    vb = v >= 56 || (rand_blank && $urandom_range(0, 15) == 0);
    hb = h >= 140 || (rand_blank && $urandom_range(0, 15) == 0);
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.vsync = vs; vin.hsync = hs; vin.vblnk = vb; vin.hblnk = hb; vin.rgb = rgb;
    hit = hi; miss = mi; clr = cl;
    q.push_back({11'(v), 11'(h), vs, vb, hs, hb, exp_rgb(h, v, vb, hb, rgb)});
    fs = h == 0 && v == 0;
    if (fs) begin s_hits = m_hits; s_miss = m_miss; end
`ifdef SCORE_BLINK_EN
    if (cl) m_blink = 0;
    else if (mi && m_miss < 99) m_blink = 31;
    else if (fs && m_blink > 0) m_blink--;
`endif
    if (cl) begin m_hits = 0; m_miss = 0; end
    else begin
      if (hi && m_hits < 99) m_hits++;
      if (mi && m_miss < 99) m_miss++;
    end
    @(posedge clk); #1;
    hit = 1'b0; miss = 1'b0; clr = 1'b0;
  endtask
  task automatic rand_xy(output int h, output int v);
    if ($urandom_range(0, 3) != 0) begin
      h = $urandom_range(36, 135); v = $urandom_range(18, 53);
    end else begin
      h = $urandom_range(0, 159); v = $urandom_range(0, 59);
    end
    if (h == 0 && v == 0) h = 1;
  endtask
  task automatic do_rst();
    rst = 1'b1; hit = 1'($urandom_range(0, 1)); miss = 1'b1; clr = 1'b0;
    vin.hcount = 11'($urandom); vin.vcount = 11'($urandom); vin.rgb = 12'($urandom);
    vin.vsync = 1'b1; vin.hsync = 1'b1; vin.vblnk = 1'b0; vin.hblnk = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; hit = 1'b0; miss = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      do_rst();
      ncmp++;
      if (obs() !== 38'h0) begin nfail++; $display("FAIL reset got=%h want=0", obs()); end
    end
  endtask
  task automatic test_passthrough();
    logic [37:0] e;
    for (int v = 0; v < 60; v++)
      for (int h = 0; h < 160; h++) begin
        cyc(h, v, 1'b0, 1'b0, 1'b0);
        e = q.pop_front(); ncmp++;
        if (obs() !== e) begin nfail++; $display("FAIL passthrough h=%0d v=%0d got=%h want=%h", h, v, obs(), e); end
      end
  endtask
  task automatic test_counts();
    logic [37:0] e;
    int h, v;
    cyc(0, 0, 1'b0, 1'b0, 1'b0);
    e = q.pop_front();
    for (int i = 0; i < 1400; i++) begin
      if (i == 600) begin h = 0; v = 0; end else rand_xy(h, v);
      cyc(h, v, i < 480 && i % 40 == 5, i % 150 == 7 && i < 450, 1'b0);
      e = q.pop_front(); ncmp++;
      if (obs() !== e) begin nfail++; $display("FAIL counts i=%0d got=%h want=%h", i, obs(), e); end
    end
    rand_blank = 1'b0;
    cyc(44, 26, 1'b0, 1'b0, 1'b0);
    e = q.pop_front();
    cyc(40, 26, 1'b0, 1'b0, 1'b0);
    e = q.pop_front(); ncmp++;
    if (vout.rgb !== 12'hFFF) begin nfail++; $display("FAIL glyph_1_row3 got=%h want=fff", vout.rgb); end
    rand_blank = 1'b1;
  endtask
  task automatic test_saturate();
    logic [37:0] e;
    int h, v;
    cyc(1, 1, 1'b0, 1'b0, 1'b1);
    e = q.pop_front();
    for (int n = 1; n <= 105; n++) begin
      for (int k = 0; k < 4; k++) begin
        rand_xy(h, v);
        cyc(h, v, k == 0, 1'b0, 1'b0);
        e = q.pop_front(); ncmp++;
        if (obs() !== e) begin nfail++; $display("FAIL saturate n=%0d got=%h want=%h", n, obs(), e); end
      end
      if (n == 10 || n == 20 || n == 105)
        for (int k = 0; k < 150; k++) begin
          if (k == 0) begin h = 0; v = 0; end
          else begin h = $urandom_range(HX, HX + 2 * CW - 1); v = $urandom_range(SY, SY + CH - 1); end
          cyc(h, v, 1'b0, 1'b0, 1'b0);
          e = q.pop_front(); ncmp++;
          if (obs() !== e) begin nfail++; $display("FAIL saturate_show n=%0d got=%h want=%h", n, obs(), e); end
        end
    end
  endtask
  task automatic test_clr_priority();
    logic [37:0] e;
    int h, v;
    cyc(1, 1, 1'b0, 1'b0, 1'b1);
    e = q.pop_front();
    for (int i = 0; i < 45; i++) begin
      rand_xy(h, v);
      cyc(h, v, 1'b1, i < 7, 1'b0);
      e = q.pop_front(); ncmp++;
      if (obs() !== e) begin nfail++; $display("FAIL clr_setup got=%h want=%h", obs(), e); end
    end
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 200; i++) begin
        if (i == 0) begin h = 0; v = 0; end else rand_xy(h, v);
        cyc(h, v, p == 1 && i == 1, p == 1 && i == 1, p == 1 && i == 1);
        e = q.pop_front(); ncmp++;
        if (obs() !== e) begin nfail++; $display("FAIL clr_priority p=%0d got=%h want=%h", p, obs(), e); end
      end
    for (int i = 0; i < 200; i++) begin
      if (i == 0) begin h = 0; v = 0; end else rand_xy(h, v);
      cyc(h, v, 1'b0, 1'b0, 1'b0);
      e = q.pop_front(); ncmp++;
      if (obs() !== e) begin nfail++; $display("FAIL clr_zero got=%h want=%h", obs(), e); end
    end
  endtask
  task automatic test_frame_edge();
    logic [37:0] e;
    int h, v;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 200; i++) begin
        if (i == 0) begin h = 0; v = 0; end else rand_xy(h, v);
        cyc(h, v, p == 0 && i == 0, 1'b0, 1'b0);
        e = q.pop_front(); ncmp++;
        if (obs() !== e) begin nfail++; $display("FAIL frame_edge p=%0d got=%h want=%h", p, obs(), e); end
      end
  endtask
  task automatic test_random();
    logic [37:0] e;
    int h, v;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 249) == 0) begin h = 0; v = 0; end else rand_xy(h, v);
      cyc(h, v, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 699) == 0);
      e = q.pop_front(); ncmp++;
      if (obs() !== e) begin nfail++; $display("FAIL random i=%0d got=%h want=%h", i, obs(), e); end
    end
  endtask
  task automatic test_reset_mid();
    logic [37:0] e;
    int h, v;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin h = 0; v = 0; end else rand_xy(h, v);
      cyc(h, v, i % 3 == 0, i % 7 == 0, 1'b0);
      e = q.pop_front(); ncmp++;
      if (obs() !== e) begin nfail++; $display("FAIL pre_reset got=%h want=%h", obs(), e); end
    end
    do_rst();
    ncmp++;
    if (obs() !== 38'h0) begin nfail++; $display("FAIL reset_mid got=%h want=0", obs()); end
    for (int i = 0; i < 300; i++) begin
      if (i == 100) begin h = 0; v = 0; end else rand_xy(h, v);
      cyc(h, v, 1'b0, 1'b0, 1'b0);
      e = q.pop_front(); ncmp++;
      if (obs() !== e) begin nfail++; $display("FAIL post_reset i=%0d got=%h want=%h", i, obs(), e); end
    end
  endtask
`ifdef SCORE_BLINK_EN
  task automatic test_blink();
    logic [37:0] e;
    int h, v;
    for (int r = 0; r < 2; r++) begin
      cyc(0, 0, 1'b0, 1'b1, 1'b0);
      e = q.pop_front();
      for (int f = 0; f < 40; f++) begin
        if (r == 1 && f == 12) begin
          do_rst();
          ncmp++;
          if (obs() !== 38'h0) begin nfail++; $display("FAIL blink_reset got=%h want=0", obs()); end
        end
        for (int i = 0; i < 41; i++) begin
          if (i == 0) begin h = 0; v = 0; end
          else begin h = $urandom_range(MX, MX + 2 * CW - 1); v = $urandom_range(SY, SY + CH - 1); end
          cyc(h, v, 1'b0, 1'b0, 1'b0);
          e = q.pop_front(); ncmp++;
          if (obs() !== e) begin nfail++; $display("FAIL blink r=%0d f=%0d got=%h want=%h", r, f, obs(), e); end
        end
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_passthrough();
    test_counts();
    test_saturate();
    test_clr_priority();
    test_frame_edge();
    test_random();
    test_reset_mid();
`ifdef SCORE_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/draw_score.md
Name: draw_score

Overview:
- Pixel-pipeline overlay stage inserted directly after draw_ball, between vga_ball and the board pins.
- Keeps two 2-digit BCD counters, HITS and MISSES, driven by single-cycle event pulses from ball_ctl.
- Renders both counters as 8x16 glyphs, scaled by SCALE, on top of the incoming picture.
- Adds exactly 2 clock cycles of latency to every VGA signal.

Parameters:
- HIT_X, 11'd40: left x of the HITS field (tens digit cell).
- MISS_X, 11'd700: left x of the MISSES field (tens digit cell).
- SCORE_Y, 11'd20: top y of both fields.
- SCALE_LOG2, 1: glyph scale is 2**SCALE_LOG2; legal values 0..2.
- FG_RGB, 12'hFFF: glyph colour.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous, active-high reset.
- hit  input  1  one-cycle pulse: ball returned by paddle.
- miss  input  1  one-cycle pulse: ball passed paddle.
- clr  input  1  level; zeroes both counters.
- vga  input  vga_if (vcount 11, hcount 11, vsync, vblnk, hsync, hblnk, rgb 12)  upstream picture.
- vga_out  output  vga_if (same fields)  overlaid picture.

Behaviour:
- Reset and synchronicity: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all vga_out fields 0. Both live counters and both shadow counters 00. Pipeline registers 0.

Counters:
- Each counter is two BCD nibbles (tens, units). It increments on its pulse: units 9 rolls to 0 and carries into tens.
- Each counter saturates at 99; further pulses are ignored.
- hit and miss in the same cycle: both counters increment.
- clr has priority over hit and miss in the same cycle. It zeroes both live counters on the next edge.
- rst has priority over everything.

Shadow / frame sync:
- Shadow counters load from the live counters only on the cycle where the input vga.vcount==0 and vga.hcount==0.
- The displayed value therefore never changes mid-frame.
- An event in the same cycle as frame start is not shown until the next frame.

Stage 1 (registered):
- Cell width CW = 8<<SCALE_LOG2, cell height CH = 16<<SCALE_LOG2.
- Field f ∈ {HITS, MISSES} is active when all of the following hold:
  - x0 <= hcount < x0+2*CW;
  - SCORE_Y <= vcount < SCORE_Y+CH;
  - vblnk==0 and hblnk==0.
- Digit select: tens when (hcount-x0) < CW, else units.
- glyph_row = (vcount-SCORE_Y)>>SCALE_LOG2 (0..15).
- glyph_col = ((hcount-x0)>>SCALE_LOG2) & 7.
- All subtractions are 11-bit, evaluated only when the field is active.
- Register digit value (4 b), glyph_row, glyph_col, active flag, and all vga fields.

Stage 2 (registered):
- Internal font ROM, digits 0-9 only. Addressed by {digit, glyph_row}, 8-bit row; bit 7 is the leftmost pixel.
- Nibble values 10-15 fetch an all-zero row.
- Output rgb = FG_RGB when active && row[7-glyph_col], otherwise the stage-1 rgb.
- All timing fields pass through unchanged.

Overlap and latency:
- HITS and MISSES fields must not overlap. If they do, HITS takes precedence.
- Latency: vga_out at cycle n+2 equals vga at cycle n, except for rgb inside active glyph pixels.
- Reset mid-frame: output returns to 0 immediately. The pipeline refills within 2 cycles; counters restart at 00.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - A 5-bit frame counter counts frame starts. Each miss pulse (not ignored by saturation, not masked by clr) reloads it to 31.
  - While the counter is nonzero it decrements at each frame start.
  - While it is nonzero, MISSES glyphs are suppressed (passthrough rgb) on frames where counter bit 2 is 1.
  - Reset and clr zero the counter.
- Not defined: no frame counter; MISSES is always drawn.

Test Plan:
- Reset, 800x600 timing → vga_out equals vga delayed exactly 2 cycles, field by field, across one full frame outside both fields; counters read 00.
- 12 hit pulses and 3 miss pulses mid-frame → the current frame still shows 00/00; the next frame shows HITS "12" and MISSES "03". Check pixels against the ROM at SCALE_LOG2=1, e.g. HITS field origin (40,20) tens cell.
- 105 hit pulses → HITS holds 99 (units carry verified at 9→10 and 19→20).
- hit, miss and clr asserted in the same cycle with counters at 45/07 → both counters become 00 next cycle.
- hit pulse in the same cycle as frame start → the value is not displayed until the following frame.
- SCORE_BLINK_EN defined, one miss → MISSES is suppressed on frames where counter bit 2 is set, for 31 frames, then drawn steadily; rst mid-blink → steady display, counters 00.
